parking_slot_billing: RTL and testbench

Parametrised multi-slot parking tracker and billing engine. It tracks occupancy of NUM_SLOTS bays and timestamps entries against an internal tick-driven clock. On each exit it computes a modulo-wrap, saturating fee, and publishes it for one cycle on a billing output. It sits between the gate/button decoder and the display/7-segment driver, and replaces the fixed three-car enter/exit block.

---
 rtl/parking_pkg.sv | 28 ++
 rtl/parking_fee_calc.sv | 34 +++
 rtl/parking_slot_billing.sv | 156 +++++++++++++++
 tb/tb_parking_slot_billing.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and the fee saturation helper for the parking tracker/billing block.
package parking_pkg;

  typedef enum logic {
    FREE     = 1'b0,
    OCCUPIED = 1'b1
  } slot_state_e;

  typedef enum logic [1:0] {
    ERR_ENTER_OCC = 2'd0,
    ERR_EXIT_FREE = 2'd1,
    ERR_BOTH      = 2'd2,
    ERR_RANGE     = 2'd3
  } err_code_e;

  localparam int unsigned FEE_CALC_W = 64;

  // Clamp a wide raw fee to the largest value representable in cost_w bits.
  function automatic logic [FEE_CALC_W-1:0] fee_saturate(
    input logic [FEE_CALC_W-1:0] raw,
    input int unsigned           cost_w
  );
    logic [FEE_CALC_W-1:0] max_fee;
    max_fee = (FEE_CALC_W'(1) << cost_w) - FEE_CALC_W'(1);
    return (raw > max_fee) ? max_fee : raw;
  endfunction

endpackage

// File: rtl/parking_fee_calc.sv
// Combinational fee: modulo-wrap elapsed ticks times RATE, saturated to COST_W bits.
// Grace period applies only when PARKING_GRACE_EN is defined.
module parking_fee_calc
  import parking_pkg::*;
#(
  parameter int unsigned TIME_W      = 10,
  parameter int unsigned COST_W      = 12,
  parameter int unsigned RATE        = 1,
  parameter int unsigned GRACE_TICKS = 5
) (
  input  logic [TIME_W-1:0] now,
  input  logic [TIME_W-1:0] stamp,
  output logic [COST_W-1:0] fee
);

`ifdef PARKING_GRACE_EN
  localparam logic [FEE_CALC_W-1:0] GRACE = FEE_CALC_W'(GRACE_TICKS);
`else
  // Grace disabled: parameter kept so both builds share one interface.
  localparam logic [FEE_CALC_W-1:0] GRACE = FEE_CALC_W'(GRACE_TICKS) & FEE_CALC_W'(0);
`endif

  logic [TIME_W-1:0]     dur;
  logic [FEE_CALC_W-1:0] billable;
  logic [FEE_CALC_W-1:0] raw;

  always_comb begin
    dur      = now - stamp;
    billable = (FEE_CALC_W'(dur) > GRACE) ? (FEE_CALC_W'(dur) - GRACE) : '0;
    raw      = billable * FEE_CALC_W'(RATE);
    fee      = COST_W'(fee_saturate(raw, COST_W));
  end

endmodule

// File: rtl/parking_slot_billing.sv
// Multi-bay occupancy tracker with tick-based timestamps and per-exit billing.
// Optional grace period selected by PARKING_GRACE_EN (see parking_fee_calc).
module parking_slot_billing
  import parking_pkg::*;
#(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned TIME_W      = 10,
  parameter int unsigned COST_W      = 12,
  parameter int unsigned RATE        = 1,
  parameter int unsigned GRACE_TICKS = 5,
  localparam int unsigned SLOT_W     = $clog2(NUM_SLOTS),
  localparam int unsigned FC_W       = $clog2(NUM_SLOTS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 car_enter,
  input  logic                 car_exit,
  input  logic [SLOT_W-1:0]    slot_id,
  output logic [NUM_SLOTS-1:0] slot_occupied,
  output logic [FC_W-1:0]      free_count,
  output logic                 full,
  output logic                 bill_valid,
  output logic [SLOT_W-1:0]    bill_slot,
  output logic [COST_W-1:0]    bill_cost,
  output logic                 err,
  output logic [1:0]           err_code
);

  slot_state_e       state_q [NUM_SLOTS];
  slot_state_e       state_n [NUM_SLOTS];
  logic [TIME_W-1:0] stamp_q [NUM_SLOTS];
  logic [TIME_W-1:0] stamp_n [NUM_SLOTS];

  logic [TIME_W-1:0] now_q, now_n;
  logic [FC_W-1:0]   free_q, free_n;
  logic              full_q, full_n;
  logic              bill_valid_q, bill_valid_n;
  logic [SLOT_W-1:0] bill_slot_q, bill_slot_n;
  logic [COST_W-1:0] bill_cost_q, bill_cost_n;
  logic              err_q, err_n;
  err_code_e         err_code_q, err_code_n;

  logic              in_range;
  logic [SLOT_W-1:0] idx;
  logic [TIME_W-1:0] stamp_sel;
  logic [COST_W-1:0] fee;

  // Out-of-range ids are steered to bay 0 so array reads stay in bounds.
  always_comb begin
    in_range  = 32'(slot_id) < NUM_SLOTS;
    idx       = in_range ? slot_id : '0;
    stamp_sel = stamp_q[idx];
  end

  parking_fee_calc #(
    .TIME_W     (TIME_W),
    .COST_W     (COST_W),
    .RATE       (RATE),
    .GRACE_TICKS(GRACE_TICKS)
  ) u_fee_calc (
    .now  (now_q),
    .stamp(stamp_sel),
    .fee  (fee)
  );

  // Next-state: conflicting request beats range check beats per-bay checks.
  always_comb begin
    state_n      = state_q;
    stamp_n      = stamp_q;
    now_n        = tick ? now_q + TIME_W'(1) : now_q;
    free_n       = free_q;
    bill_valid_n = 1'b0;
    bill_slot_n  = bill_slot_q;
    bill_cost_n  = bill_cost_q;
    err_n        = 1'b0;
    err_code_n   = err_code_q;

    if (car_enter && car_exit) begin
      err_n      = 1'b1;
      err_code_n = ERR_BOTH;
    end else if (car_enter || car_exit) begin
      if (!in_range) begin
        err_n      = 1'b1;
        err_code_n = ERR_RANGE;
      end else if (car_enter) begin
        if (state_q[idx] == OCCUPIED) begin
          err_n      = 1'b1;
          err_code_n = ERR_ENTER_OCC;
        end else begin
          state_n[idx] = OCCUPIED;
          stamp_n[idx] = now_q;
          free_n       = free_q - FC_W'(1);
        end
      end else begin
        if (state_q[idx] == FREE) begin
          err_n      = 1'b1;
          err_code_n = ERR_EXIT_FREE;
        end else begin
          state_n[idx] = FREE;
          free_n       = free_q + FC_W'(1);
          bill_valid_n = 1'b1;
          bill_slot_n  = idx;
          bill_cost_n  = fee;
        end
      end
    end

    full_n = (free_n == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        state_q[i] <= FREE;
        stamp_q[i] <= '0;
      end
      now_q        <= '0;
      free_q       <= FC_W'(NUM_SLOTS);
      full_q       <= 1'b0;
      bill_valid_q <= 1'b0;
      bill_slot_q  <= '0;
      bill_cost_q  <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_ENTER_OCC;
    end else begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) begin
        state_q[i] <= state_n[i];
        stamp_q[i] <= stamp_n[i];
      end
      now_q        <= now_n;
      free_q       <= free_n;
      full_q       <= full_n;
      bill_valid_q <= bill_valid_n;
      bill_slot_q  <= bill_slot_n;
      bill_cost_q  <= bill_cost_n;
      err_q        <= err_n;
      err_code_q   <= err_code_n;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      slot_occupied[i] = (state_q[i] == OCCUPIED);
    end
  end

  assign free_count = free_q;
  assign full       = full_q;
  assign bill_valid = bill_valid_q;
  assign bill_slot  = bill_slot_q;
  assign bill_cost  = bill_cost_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_parking_slot_billing.sv
// Directed bench: default 4-bay instance plus a 5-bay, RATE=8, COST_W=6 instance.
module tb_parking_slot_billing;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic       tick_a = 0, enter_a = 0, exit_a = 0;
  logic [1:0] slot_a = '0;
  logic [3:0] occ_a;
  logic [2:0] free_a;
  logic       full_a, bv_a, err_a;
  logic [1:0] bslot_a, ecode_a;
  logic [11:0] bcost_a;

  parking_slot_billing dut (
    .clk(clk), .reset(reset), .tick(tick_a), .car_enter(enter_a), .car_exit(exit_a),
    .slot_id(slot_a), .slot_occupied(occ_a), .free_count(free_a), .full(full_a),
    .bill_valid(bv_a), .bill_slot(bslot_a), .bill_cost(bcost_a), .err(err_a),
    .err_code(ecode_a)
  );

  // Instance B: 5 bays, steep rate, narrow fee
  logic       tick_b = 0, enter_b = 0, exit_b = 0;
  logic [2:0] slot_b = '0;
  logic [4:0] occ_b;
  logic [2:0] free_b;
  logic       full_b, bv_b, err_b;
  logic [2:0] bslot_b;
  logic [1:0] ecode_b;
  logic [5:0] bcost_b;

  parking_slot_billing #(.NUM_SLOTS(5), .TIME_W(10), .COST_W(6), .RATE(8), .GRACE_TICKS(5)) dut_b (
    .clk(clk), .reset(reset), .tick(tick_b), .car_enter(enter_b), .car_exit(exit_b),
    .slot_id(slot_b), .slot_occupied(occ_b), .free_count(free_b), .full(full_b),
    .bill_valid(bv_b), .bill_slot(bslot_b), .bill_cost(bcost_b), .err(err_b),
    .err_code(ecode_b)
  );

`ifdef PARKING_GRACE_EN
  localparam int EXP_A_DUR12 = 7;
  localparam int EXP_A_WRAP  = 3;
  localparam int EXP_B_DUR3  = 0;
`else
  localparam int EXP_A_DUR12 = 12;
  localparam int EXP_A_WRAP  = 8;
  localparam int EXP_B_DUR3  = 24;
`endif

  int tests = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic req_a(input logic e, input logic x, input logic [1:0] id);
    @(negedge clk);
    enter_a = e; exit_a = x; slot_a = id;
    @(negedge clk);
    enter_a = 0; exit_a = 0;
  endtask

  task automatic req_b(input logic e, input logic x, input logic [2:0] id);
    @(negedge clk);
    enter_b = e; exit_b = x; slot_b = id;
    @(negedge clk);
    enter_b = 0; exit_b = 0;
  endtask

  task automatic ticks_a(input int n);
    @(negedge clk);
    tick_a = 1;
    repeat (n) @(negedge clk);
    tick_a = 0;
  endtask

  task automatic ticks_b(input int n);
    @(negedge clk);
    tick_b = 1;
    repeat (n) @(negedge clk);
    tick_b = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 0;

    chk("rst_occ", 32'(occ_a), 0);
    chk("rst_free", 32'(free_a), 4);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_bv", 32'(bv_a), 0);
    chk("rst_bslot", 32'(bslot_a), 0);
    chk("rst_bcost", 32'(bcost_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_ecode", 32'(ecode_a), 0);

    // Enter bay 2 at now=7, exit at now=19
    ticks_a(7);
    req_a(1, 0, 2);
    chk("enter2_occ", 32'(occ_a), 32'h4);
    chk("enter2_free", 32'(free_a), 3);
    ticks_a(12);
    req_a(0, 1, 2);
    chk("exit2_bv", 32'(bv_a), 1);
    chk("exit2_slot", 32'(bslot_a), 2);
    chk("exit2_cost", 32'(bcost_a), 32'(EXP_A_DUR12));
    chk("exit2_free", 32'(free_a), 4);
    @(negedge clk);
    chk("exit2_bv_drop", 32'(bv_a), 0);
    chk("exit2_cost_hold", 32'(bcost_a), 32'(EXP_A_DUR12));

    // Wrap: enter bay 0 at now=1020, exit at now=4
    ticks_a(1001);
    req_a(1, 0, 0);
    ticks_a(8);
    req_a(0, 1, 0);
    chk("wrap_bv", 32'(bv_a), 1);
    chk("wrap_slot", 32'(bslot_a), 0);
    chk("wrap_cost", 32'(bcost_a), 32'(EXP_A_WRAP));

    // Fill all bays, then enter an occupied one
    req_a(1, 0, 0);
    req_a(1, 0, 1);
    req_a(1, 0, 2);
    req_a(1, 0, 3);
    chk("fill_full", 32'(full_a), 1);
    chk("fill_free", 32'(free_a), 0);
    chk("fill_occ", 32'(occ_a), 32'hF);
    req_a(1, 0, 1);
    chk("occ_err", 32'(err_a), 1);
    chk("occ_ecode", 32'(ecode_a), 0);
    chk("occ_state", 32'(occ_a), 32'hF);
    chk("occ_free", 32'(free_a), 0);
    @(negedge clk);
    chk("occ_err_drop", 32'(err_a), 0);

    // Exit bay 3 (dur 0), then exit it again while free
    req_a(0, 1, 3);
    chk("exit3_cost", 32'(bcost_a), 0);
    chk("exit3_full", 32'(full_a), 0);
    req_a(0, 1, 3);
    chk("free_err", 32'(err_a), 1);
    chk("free_ecode", 32'(ecode_a), 1);
    chk("free_nobill", 32'(bv_a), 0);
    req_a(1, 1, 3);
    chk("both_err", 32'(err_a), 1);
    chk("both_ecode", 32'(ecode_a), 2);
    chk("both_occ", 32'(occ_a), 32'h7);
    @(negedge clk);
    chk("ecode_hold", 32'(ecode_a), 2);

    // Instance B: range errors, saturation and short stay
    chk("b_rst_free", 32'(free_b), 5);
    req_b(1, 0, 5);
    chk("b_range_err", 32'(err_b), 1);
    chk("b_range_ecode", 32'(ecode_b), 3);
    chk("b_range_free", 32'(free_b), 5);
    req_b(1, 0, 4);
    chk("b_enter4_occ", 32'(occ_b), 32'h10);
    ticks_b(20);
    req_b(0, 1, 4);
    chk("b_sat_bv", 32'(bv_b), 1);
    chk("b_sat_slot", 32'(bslot_b), 4);
    chk("b_sat_cost", 32'(bcost_b), 63);
    req_b(1, 0, 0);
    ticks_b(3);
    req_b(0, 1, 0);
    chk("b_short_slot", 32'(bslot_b), 0);
    chk("b_short_cost", 32'(bcost_b), 32'(EXP_B_DUR3));

    // Mid-operation reset with bays 0,1 occupied and a bill showing
    req_a(0, 1, 2);
    chk("pre_rst_bv", 32'(bv_a), 1);
    chk("pre_rst_occ", 32'(occ_a), 32'h3);
    #2 reset = 1;
    #1;
    chk("mid_rst_occ", 32'(occ_a), 0);
    chk("mid_rst_free", 32'(free_a), 4);
    chk("mid_rst_full", 32'(full_a), 0);
    chk("mid_rst_bv", 32'(bv_a), 0);
    chk("mid_rst_bslot", 32'(bslot_a), 0);
    chk("mid_rst_bcost", 32'(bcost_a), 0);
    chk("mid_rst_err", 32'(err_a), 0);
    chk("mid_rst_ecode", 32'(ecode_a), 0);
    chk("mid_rst_b_occ", 32'(occ_b), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
